modn_seq_ctrl: RTL

Sequencer for the mod-N counting datapath. It accepts a command over a valid/ready handshake carrying a modulus N and a repeat count R. It then runs a synchronous 0..N-1 count R times, emitting a terminal-count pulse on every wrap and a single-cycle done pulse at the end. It replaces hard-wired clear decoding: modulus, run length and abort are controlled by the surrounding logic.

---
 rtl/modn_seq_ctrl.sv | 116 +++++++++++
 1 files changed

// File: rtl/modn_seq_ctrl.sv
// modn_seq_ctrl
//   Sequencer for a mod-N counting datapath. A command on a valid/ready
//   handshake carries modulus N (cmd_mod, 0 encodes 2^W) and repeat count R
//   (cmd_reps, 0 runs until abort). The block counts 0..N-1 R times, pulses
//   tc on every wrap and pulses done for one cycle after the final wrap.
//
// Ports
//   clk        rising-edge clock
//   rst        synchronous active-high reset
//   cmd_valid  command present
//   cmd_ready  command can be accepted (IDLE and not in reset)
//   cmd_mod    modulus N, 0 means 2^W
//   cmd_reps   repeat count R, 0 means run until abort
//   abort      terminate a run in progress (only honoured in RUN)
//   count      current count value
//   tc         count is at N-1 while running
//   busy       run in progress
//   done       one-cycle pulse after the last wrap of a finite run

module modn_seq_ctrl #(
    parameter int W  = 3,
    parameter int RW = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          cmd_valid,
    output logic          cmd_ready,
    input  logic [W-1:0]  cmd_mod,
    input  logic [RW-1:0] cmd_reps,
    input  logic          abort,
    output logic [W-1:0]  count,
    output logic          tc,
    output logic          busy,
    output logic          done
);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t        state, state_nx;
    logic [W-1:0]  count_nx;
    logic [W-1:0]  last, last_nx;
    logic [RW-1:0] reps, reps_nx;
    logic [RW-1:0] repcnt, repcnt_nx;
    logic          final_wrap;

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            count  <= '0;
            last   <= '0;
            reps   <= '0;
            repcnt <= '0;
        end else begin
            state  <= state_nx;
            count  <= count_nx;
            last   <= last_nx;
            reps   <= reps_nx;
            repcnt <= repcnt_nx;
        end
    end

    always_comb begin
        cmd_ready  = (state == IDLE) && !rst;
        busy       = (state == RUN);
        done       = (state == DONE);
        tc         = busy && (count == last);
        // reps==0 never matches here, so a free run only ends on abort
        final_wrap = tc && (reps != '0) && (repcnt == reps - RW'(1));

        state_nx  = state;
        count_nx  = count;
        last_nx   = last;
        reps_nx   = reps;
        repcnt_nx = repcnt;

        unique case (state)
            IDLE: begin
                if (cmd_valid && cmd_ready) begin
                    state_nx  = RUN;
                    // W-bit wrap: cmd_mod==0 yields all-ones, i.e. N=2^W
                    last_nx   = cmd_mod - W'(1);
                    reps_nx   = cmd_reps;
                    repcnt_nx = '0;
                    count_nx  = '0;
                end
            end
            RUN: begin
                if (abort) begin
                    state_nx = IDLE;
                    count_nx = '0;
                end else if (tc) begin
                    count_nx  = '0;
                    repcnt_nx = repcnt + RW'(1);
                    if (final_wrap) begin
                        state_nx = DONE;
                    end
                end else begin
                    count_nx = count + W'(1);
                end
            end
            DONE: begin
                state_nx = IDLE;
                count_nx = '0;
            end
            default: begin
                state_nx = IDLE;
                count_nx = '0;
            end
        endcase
    end

endmodule
